clock_field_editor: RTL and testbench

//  Parametrised run/edit controller for the alarm clock. It sits between the

---
 rtl/clock_field_editor.sv | 137 +++++++++++++
 tb/tb_clock_field_editor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clock_field_editor.sv
// rtl/clock_field_editor.sv - run/edit controller: field select, wrap-limited value editing, commit pulse
// Optional idle auto-abort in EDIT is built when EDIT_TIMEOUT_EN is defined.
module clock_field_editor #(
    parameter int                          NUM_FIELDS  = 4,
    parameter int                          VAL_W       = 6,
    parameter logic [NUM_FIELDS*VAL_W-1:0] FIELD_MAX   = {6'd59, 6'd23, 6'd59, 6'd23},
    parameter int                          TIMEOUT_CYC = 2400
) (
    input  logic                          clk_out,
    input  logic                          rst,
    input  logic                          btn_c,
    input  logic                          btn_u,
    input  logic                          btn_d,
    input  logic                          btn_l,
    input  logic                          btn_r,
    input  logic [NUM_FIELDS*VAL_W-1:0]   cur_vals,
    output logic [NUM_FIELDS*VAL_W-1:0]   edit_vals,
    output logic                          commit,
    output logic                          enable_clk,
    output logic                          run_led,
    output logic [NUM_FIELDS-1:0]         field_led
);

    localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);

    generate
        if (NUM_FIELDS < 2) begin : g_bad_num_fields
            $error("clock_field_editor: NUM_FIELDS must be at least 2");
        end
    endgenerate

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [VAL_W-1:0]   vals [NUM_FIELDS];
    logic               valid_press;
    logic [VAL_W-1:0]   sel_val;
    logic [VAL_W-1:0]   sel_max;

    function automatic logic [VAL_W-1:0] field_max(input int idx);
        return FIELD_MAX[idx*VAL_W +: VAL_W];
    endfunction

    // Anything other than a single button in a cycle is treated as noise.
    assign valid_press = $onehot({btn_c, btn_u, btn_d, btn_l, btn_r});

    always_comb begin
        sel_val = vals[sel];
        sel_max = FIELD_MAX[int'(sel)*VAL_W +: VAL_W];
    end

`ifdef EDIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            sel    <= '0;
            commit <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                vals[i] <= '0;
            end
`ifdef EDIT_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            commit <= 1'b0;
            case (state)
                ST_RUN: begin
`ifdef EDIT_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (valid_press && btn_c) begin
                        state <= ST_EDIT;
                        sel   <= '0;
                        // Snapshot clamped so editing never starts above a field's limit.
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            if (cur_vals[i*VAL_W +: VAL_W] > field_max(i)) begin
                                vals[i] <= field_max(i);
                            end else begin
                                vals[i] <= cur_vals[i*VAL_W +: VAL_W];
                            end
                        end
                    end
                end
                ST_EDIT: begin
                    if (valid_press) begin
`ifdef EDIT_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (btn_c) begin
                            state  <= ST_RUN;
                            commit <= 1'b1;
                        end else if (btn_r) begin
                            sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                        end else if (btn_l) begin
                            sel <= (sel == '0) ? SEL_LAST : sel - 1'b1;
                        end else if (btn_u) begin
                            vals[sel] <= (sel_val >= sel_max) ? '0 : sel_val + 1'b1;
                        end else begin
                            vals[sel] <= (sel_val == '0) ? sel_max : sel_val - 1'b1;
                        end
                    end
`ifdef EDIT_TIMEOUT_EN
                    else if (idle_cnt == TO_LAST) begin
                        state    <= ST_RUN;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_FIELDS; g++) begin : g_pack
            assign edit_vals[g*VAL_W +: VAL_W] = vals[g];
        end
    endgenerate

    assign enable_clk = (state == ST_RUN);
    assign run_led    = (state == ST_RUN);
    assign field_led  = (state == ST_EDIT) ? (NUM_FIELDS'(1) << sel) : '0;

endmodule

// File: tb/tb_clock_field_editor.sv
// tb/tb_clock_field_editor.sv - directed self-checking bench for clock_field_editor
module tb_clock_field_editor;

    logic        clk_out = 1'b0;
    logic        rst = 1'b1;
    logic        btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [23:0] cur_vals = '0;
    logic [23:0] edit_vals;
    logic        commit, enable_clk, run_led;
    logic [3:0]  field_led;

    int vectors = 0;
    int miscompares = 0;

    clock_field_editor #(
        .NUM_FIELDS (4),
        .VAL_W      (6),
        .FIELD_MAX  ({6'd59, 6'd23, 6'd59, 6'd23}),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk_out   (clk_out),
        .rst       (rst),
        .btn_c     (btn_c),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .cur_vals  (cur_vals),
        .edit_vals (edit_vals),
        .commit    (commit),
        .enable_clk(enable_clk),
        .run_led   (run_led),
        .field_led (field_led)
    );

    always #5 clk_out = ~clk_out;

    function automatic logic [23:0] pk(input int f3, input int f2, input int f1, input int f0);
        return {6'(f3), 6'(f2), 6'(f1), 6'(f0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive {c,u,d,l,r} from one negedge to the next so a single posedge samples it.
    task automatic press(input logic [4:0] b);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
        @(negedge clk_out);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
    endtask

    localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

    initial begin
        repeat (2) @(negedge clk_out);
        rst = 1'b0;
        @(negedge clk_out);
        check("rst_run_led", run_led, 1);
        check("rst_enable_clk", enable_clk, 1);
        check("rst_field_led", field_led, 4'b0000);
        check("rst_commit", commit, 0);
        check("rst_edit_vals", edit_vals, 0);

        press(U);
        check("run_btn_u_ignored", {run_led, field_led}, 5'b10000);

        cur_vals = pk(59, 23, 30, 12);
        press(C);
        check("entry_enable_clk", enable_clk, 0);
        check("entry_run_led", run_led, 0);
        check("entry_field_led", field_led, 4'b0001);
        check("entry_edit_vals", edit_vals, pk(59, 23, 30, 12));
        check("entry_commit", commit, 0);

        press(L);
        check("sel_wrap_left", field_led, 4'b1000);
        press(R);
        check("sel_wrap_right", field_led, 4'b0001);
        press(R);
        check("sel_right", field_led, 4'b0010);
        press(L);
        check("sel_left", field_led, 4'b0001);

        repeat (11) press(U);
        check("f0_up_to_max", edit_vals, pk(59, 23, 30, 23));
        press(U);
        check("f0_up_wrap", edit_vals, pk(59, 23, 30, 0));
        press(D);
        check("f0_down_wrap", edit_vals, pk(59, 23, 30, 23));

        press(R);
        repeat (30) press(D);
        check("f1_down_to_zero", edit_vals, pk(59, 23, 0, 23));
        press(D);
        check("f1_down_wrap", edit_vals, pk(59, 23, 59, 23));

        press(R);
        press(R);
        press(U);
        check("f3_up_wrap", edit_vals, pk(0, 23, 59, 23));

        press(U | R);
        check("multi_ur_sel", field_led, 4'b1000);
        check("multi_ur_vals", edit_vals, pk(0, 23, 59, 23));
        press(C | L);
        check("multi_cl_state", {run_led, commit, field_led}, 6'b001000);

        cur_vals = pk(1, 2, 3, 4);
        press(C);
        check("commit_pulse", commit, 1);
        check("commit_vals", edit_vals, pk(0, 23, 59, 23));
        check("commit_run_led", run_led, 1);
        check("commit_field_led", field_led, 4'b0000);
        @(negedge clk_out);
        check("commit_one_cycle", commit, 0);
        check("commit_vals_held", edit_vals, pk(0, 23, 59, 23));
        check("commit_enable_clk", enable_clk, 1);

        cur_vals = pk(63, 30, 63, 5);
        press(C);
        check("clamp_entry", edit_vals, pk(59, 23, 59, 5));
        press(U);
        check("clamp_f0_up", edit_vals, pk(59, 23, 59, 6));

        #2 rst = 1'b1;
        #1;
        check("async_rst_run_led", run_led, 1);
        check("async_rst_vals", edit_vals, 0);
        check("async_rst_commit", commit, 0);
        check("async_rst_field_led", field_led, 4'b0000);
        @(negedge clk_out);
        rst = 1'b0;
        @(negedge clk_out);
        check("post_rst_commit", commit, 0);
        check("post_rst_run_led", run_led, 1);

        cur_vals = pk(10, 11, 12, 13);
        press(C);
        repeat (7) @(negedge clk_out);
        check("idle7_still_edit", run_led, 0);
        @(negedge clk_out);
`ifdef EDIT_TIMEOUT_EN
        check("timeout_run_led", run_led, 1);
        check("timeout_commit", commit, 0);
        check("timeout_vals_kept", edit_vals, pk(10, 11, 12, 13));
`else
        repeat (4) @(negedge clk_out);
        check("no_timeout_edit", run_led, 0);
        check("no_timeout_field_led", field_led, 4'b0001);
        press(C);
        check("late_commit", commit, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
